snn_image_loader: RTL and testbench
===================================

Name: snn_image_loader

Overview:
- Upstream feeder for snn_core. Takes 8-bit bytes from the UART receiver and unpacks each one, LSB first, into a 784 x 1-bit image memory.
- Serves that memory to snn_core through its addr_input_unit/q_input read port.
- Pulses start once a full image is loaded, then holds off new bytes until snn_core reports done.

Parameters:
NUM_PIXELS, 784, image size in 1-bit pixels; must be a multiple of 8
IMG_BYTES, NUM_PIXELS/8 (98), bytes per image frame
PIX_W, 10, width of pixel address/counter

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
rx_rdy  in  1  UART has a byte; held high until cleared
rx_data  in  8  UART received byte
clr_rx_rdy  out  1  consume the byte; one-cycle pulse
addr_input_unit  in  PIX_W  pixel read address from snn_core
q_input  out  1  pixel at addr_input_unit; registered
start  out  1  one-cycle pulse to snn_core; image ready
core_done  in  1  snn_core done pulse
busy  out  1  high from first accepted byte until core_done
frame_err  out  1  one-cycle checksum-failure pulse; tied 0 unless IMG_CHECKSUM_EN

Behaviour:
- Clock/reset: single clock clk; reset rst_n asynchronous, active-low.
- Reset values: state IDLE; pix_cnt=0; bit_cnt=0; shreg=0; clr_rx_rdy=0; q_input=0; start=0; busy=0; frame_err=0.
- Image memory contents are not reset.
- Reset mid-load: the partial frame is discarded and the next byte starts pixel 0.
- Read port:
  - q_input <= mem[addr_input_unit] on every clk edge, in every state; 1-cycle latency.
  - Addresses >= NUM_PIXELS return 0.
  - Reads during a load return whatever is stored; no interlock.
- States (enum): IDLE, UNPACK, CHECK (only with IMG_CHECKSUM_EN), START, WAIT_DONE.
- IDLE:
  - clr_rx_rdy = rx_rdy (combinational).
  - On rx_rdy: shreg <= rx_data, bit_cnt <= 0, go UNPACK.
  - busy is 1 if pix_cnt != 0.
- UNPACK, 8 cycles:
  - Each cycle: mem[pix_cnt] <= shreg[0]; shreg >>= 1; pix_cnt++; bit_cnt++.
  - After bit_cnt==7:
    - pix_cnt reaching NUM_PIXELS -> START, or CHECK if the macro is enabled.
    - Otherwise -> IDLE.
  - rx_rdy is ignored here; the UART holds the byte, so nothing is lost.
- Latency:
  - Byte captured at edge E0; its bits are written at E1..E8; back in IDLE after E8.
  - Sustained accept rate: one byte per 9 cycles.
  - For the last byte, start is high in the cycle after E8.
- START:
  - start=1 for exactly one cycle; pix_cnt <= 0; go WAIT_DONE.
- WAIT_DONE:
  - busy=1; clr_rx_rdy=0; pending bytes wait.
  - On core_done: go IDLE, busy drops the next cycle.
  - core_done in any other state is ignored.
- Simultaneous events:
  - rx_rdy together with core_done in WAIT_DONE: the byte is not consumed that cycle; it is consumed on the first IDLE cycle.
  - start is never reasserted before core_done.
- Arithmetic:
  - pix_cnt is an unsigned PIX_W-bit counter; it never wraps because it is cleared at NUM_PIXELS.
  - bit_cnt is 3 bits and wraps 7->0.

Optional Feature:
- Macro IMG_CHECKSUM_EN.
- When defined:
  - Each frame is followed by one extra checksum byte equal to the XOR of all IMG_BYTES data bytes.
  - A running XOR register is cleared in START/error and updated on each accepted data byte.
  - CHECK waits for rx_rdy and consumes the byte with clr_rx_rdy.
  - Match -> START.
  - Mismatch -> frame_err=1 for one cycle, pix_cnt <= 0, IDLE, no start.
- When undefined:
  - No CHECK state, no XOR register, frame_err tied 0.
  - Start follows the last data byte directly.

Decomposition:
- Package snn_pkg holds:
  - NUM_PIXELS, IMG_BYTES, PIX_W
  - loader_state_t enum; it is shared with snn_core's testbench monitors.
- One sub-module, ram_input_unit: NUM_PIXELS x 1 synchronous single-port RAM.
  - Ports: d, wr_addr, we, rd_addr, clk, q.
  - One write port and one registered read port.
  - Inferred as block RAM.

Test Plan:
- All-ones frame: 98 x 0xFF, rx_rdy gaps of 0-20 cycles.
  - All 784 addresses read q_input=1.
  - Exactly one start pulse, 9 cycles after the final byte's capture edge.
- Pattern frame: byte k = 0x01 for all k.
  - q_input=1 only at addresses 8k; address 783 = 0.
  - Address 800 reads 0.
- Backpressure: send byte 99 during WAIT_DONE.
  - No clr_rx_rdy until the cycle after core_done.
  - The byte becomes pixel 0-7 of the next frame.
  - Second start only after 98 more bytes.
- Reset mid-frame: assert rst_n=0 after 50 bytes, release, send a full 0xA5 frame.
  - Pixels follow the 1,0,1,0,0,1,0,1 pattern per byte.
  - Exactly one start.
- Simultaneous event: core_done and rx_rdy in the same WAIT_DONE cycle.
  - clr_rx_rdy=0 that cycle and 1 the next cycle.
  - busy toggles 1->0->1.
- Checksum (IMG_CHECKSUM_EN):
  - 98 bytes 0x3C + checksum 0x00 -> start.
  - Checksum 0x01 -> frame_err pulse, no start, next good frame accepted.

Source files
------------

// File: rtl/snn_pkg.sv
// snn_pkg: shared constants and the loader state type for the SNN image path.
//
// Contents:
//   NUM_PIXELS     - image size in 1-bit pixels (a multiple of 8)
//   IMG_BYTES      - bytes per image frame (NUM_PIXELS / 8)
//   PIX_W          - width of pixel addresses and the pixel counter
//   loader_state_t - snn_image_loader FSM states; snn_core bench monitors
//                    also decode this type.
//
// Configuration macro: IMG_CHECKSUM_EN adds the CHECK state.
package snn_pkg;

  localparam int NUM_PIXELS = 784;
  localparam int IMG_BYTES  = NUM_PIXELS / 8;
  localparam int PIX_W      = 10;

  // Encodings are pinned so that external monitors decode states the same
  // way in both build flavours.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    UNPACK    = 3'd1,
`ifdef IMG_CHECKSUM_EN
    CHECK     = 3'd2,
`endif
    START     = 3'd3,
    WAIT_DONE = 3'd4
  } loader_state_t;

endpackage

// File: rtl/ram_input_unit.sv
// ram_input_unit: NUM_PIXELS x 1 synchronous RAM holding one binary image.
//
// Ports:
//   d        in  1      write data
//   wr_addr  in  AW     write address
//   we       in  1      write enable
//   rd_addr  in  AW     read address
//   clk      in  1      clock
//   q        out 1      registered read data (one-cycle latency)
//
// No reset on the array or the read register so that the tools can map it
// onto a block RAM. A read and a write to the same address in the same cycle
// returns the old contents.
module ram_input_unit
  import snn_pkg::*;
#(
  parameter int DEPTH = NUM_PIXELS,
  parameter int AW    = PIX_W
) (
  input  logic          d,
  input  logic [AW-1:0] wr_addr,
  input  logic          we,
  input  logic [AW-1:0] rd_addr,
  input  logic          clk,
  output logic          q
);

  logic mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= d;
    end
  end

  always_ff @(posedge clk) begin
    q <= mem[rd_addr];
  end

endmodule

// File: rtl/snn_image_loader.sv
// snn_image_loader: accepts bytes from the UART receiver, unpacks each one
// LSB first into a NUM_PIXELS x 1-bit image RAM, pulses start to snn_core
// once a full frame is stored, then holds off further bytes until core_done.
//
// Ports:
//   clk              in  1      system clock
//   rst_n            in  1      asynchronous active-low reset
//   rx_rdy           in  1      UART has a byte (held until cleared)
//   rx_data          in  8      UART byte
//   clr_rx_rdy       out 1      consume the current byte (one-cycle pulse)
//   addr_input_unit  in  PIX_W  pixel read address from snn_core
//   q_input          out 1      pixel at addr_input_unit, one-cycle latency
//   start            out 1      one-cycle pulse: image ready
//   core_done        in  1      snn_core finished with the image
//   busy             out 1      high from first byte of a frame until core_done
//   frame_err        out 1      one-cycle checksum failure pulse
//
// Configuration macro: IMG_CHECKSUM_EN. When defined, every frame is followed
// by an XOR checksum byte that must match before start is issued; when
// undefined, frame_err is tied low and start follows the last data byte.
module snn_image_loader
  import snn_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rx_rdy,
  input  logic [7:0]       rx_data,
  output logic             clr_rx_rdy,
  input  logic [PIX_W-1:0] addr_input_unit,
  output logic             q_input,
  output logic             start,
  input  logic             core_done,
  output logic             busy,
  output logic             frame_err
);

  localparam logic [PIX_W-1:0] PIX_LIMIT = PIX_W'(NUM_PIXELS);
  localparam logic [PIX_W-1:0] LAST_PIX  = PIX_W'(NUM_PIXELS - 1);

  loader_state_t    state_reg, state_next;
  logic [PIX_W-1:0] pix_cnt_reg, pix_cnt_next;
  logic [2:0]       bit_cnt_reg, bit_cnt_next;
  logic [7:0]       shreg_reg, shreg_next;
  logic             rd_ok_reg;
  logic             ram_we;
  logic             ram_q;
`ifdef IMG_CHECKSUM_EN
  logic [7:0]       xor_reg, xor_next;
`endif

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      pix_cnt_reg <= '0;
      bit_cnt_reg <= '0;
      shreg_reg   <= '0;
      rd_ok_reg   <= 1'b0;
`ifdef IMG_CHECKSUM_EN
      xor_reg     <= '0;
`endif
    end else begin
      state_reg   <= state_next;
      pix_cnt_reg <= pix_cnt_next;
      bit_cnt_reg <= bit_cnt_next;
      shreg_reg   <= shreg_next;
      rd_ok_reg   <= (addr_input_unit < PIX_LIMIT);
`ifdef IMG_CHECKSUM_EN
      xor_reg     <= xor_next;
`endif
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_next   = state_reg;
    pix_cnt_next = pix_cnt_reg;
    bit_cnt_next = bit_cnt_reg;
    shreg_next   = shreg_reg;
`ifdef IMG_CHECKSUM_EN
    xor_next     = xor_reg;
`endif
    clr_rx_rdy   = 1'b0;
    start        = 1'b0;
    frame_err    = 1'b0;
    busy         = 1'b1;
    ram_we       = 1'b0;

    case (state_reg)
      IDLE: begin
        // Between bytes of a frame the loader is still busy.
        busy       = (pix_cnt_reg != '0);
        clr_rx_rdy = rx_rdy;
        if (rx_rdy) begin
          shreg_next   = rx_data;
          bit_cnt_next = '0;
          state_next   = UNPACK;
`ifdef IMG_CHECKSUM_EN
          xor_next     = xor_reg ^ rx_data;
`endif
        end
      end

      UNPACK: begin
        // One pixel per cycle, LSB of the byte first.
        ram_we       = 1'b1;
        shreg_next   = {1'b0, shreg_reg[7:1]};
        pix_cnt_next = pix_cnt_reg + PIX_W'(1);
        bit_cnt_next = bit_cnt_reg + 3'd1;
        if (bit_cnt_reg == 3'd7) begin
          if (pix_cnt_reg == LAST_PIX) begin
`ifdef IMG_CHECKSUM_EN
            state_next = CHECK;
`else
            state_next = START;
`endif
          end else begin
            state_next = IDLE;
          end
        end
      end

`ifdef IMG_CHECKSUM_EN
      CHECK: begin
        clr_rx_rdy = rx_rdy;
        if (rx_rdy) begin
          if (rx_data == xor_reg) begin
            state_next = START;
          end else begin
            // Bad frame: drop it and start over at pixel 0.
            frame_err    = 1'b1;
            pix_cnt_next = '0;
            xor_next     = '0;
            state_next   = IDLE;
          end
        end
      end
`endif

      START: begin
        start        = 1'b1;
        pix_cnt_next = '0;
`ifdef IMG_CHECKSUM_EN
        xor_next     = '0;
`endif
        state_next   = WAIT_DONE;
      end

      WAIT_DONE: begin
        // Pending UART bytes wait here; the first is taken in the next IDLE.
        if (core_done) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  ram_input_unit #(
    .DEPTH(NUM_PIXELS),
    .AW   (PIX_W)
  ) u_ram (
    .d      (shreg_reg[0]),
    .wr_addr(pix_cnt_reg),
    .we     (ram_we),
    .rd_addr(addr_input_unit),
    .clk    (clk),
    .q      (ram_q)
  );

  // Both terms are registered on the same edge: out-of-range addresses read
  // as 0, and the pixel output is 0 straight out of reset.
  assign q_input = ram_q & rd_ok_reg;

endmodule

// File: tb/tb_snn_image_loader.sv
// Bench for snn_image_loader: directed frames, a transaction-level model of
// the byte/start/busy timing and of the image contents, checked every cycle,
// plus literal spot checks of individual pixels and pulse counts.
module tb_snn_image_loader;
  import snn_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             rx_rdy = 1'b0;
  logic [7:0]       rx_data = 8'h00;
  logic             clr_rx_rdy;
  logic [PIX_W-1:0] addr_input_unit = '0;
  logic             q_input;
  logic             start;
  logic             core_done = 1'b0;
  logic             busy;
  logic             frame_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  snn_image_loader dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rx_rdy         (rx_rdy),
    .rx_data        (rx_data),
    .clr_rx_rdy     (clr_rx_rdy),
    .addr_input_unit(addr_input_unit),
    .q_input        (q_input),
    .start          (start),
    .core_done      (core_done),
    .busy           (busy),
    .frame_err      (frame_err)
  );

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // ---------------- model ----------------
  // A byte accepted in the cycle sampled at cycle count k is captured on the
  // next edge c0 = k+1; its 8 pixels are written over the following 8 edges,
  // so the loader can take another byte (or raises start) in cycle c0+8.
  bit         model_mem [NUM_PIXELS];
  int         cyc = 0;
  int         m_pix = 0;
  int         m_free_at = 0;
  int         m_start_due = -1;
  bit         m_waiting = 1'b0;
  bit         m_ck_pending = 1'b0;
  logic [7:0] m_xor = 8'h00;
  int         start_count = 0;
  int         err_count = 0;
  bit         qchk = 1'b0;
  bit         qchk_q = 1'b0;
  logic [PIX_W-1:0] addr_q = '0;
  bit         exp_clr, exp_err, exp_q;

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    addr_q <= addr_input_unit;
    qchk_q <= qchk;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      m_pix = 0; m_free_at = 0; m_start_due = -1;
      m_waiting = 1'b0; m_ck_pending = 1'b0; m_xor = 8'h00;
      check("reset_start", start, 0);
      check("reset_busy", busy, 0);
      check("reset_frame_err", frame_err, 0);
      check("reset_q_input", q_input, 0);
    end else begin
      exp_clr = rx_rdy && !m_waiting && (cyc >= m_free_at);
      exp_err = m_ck_pending && exp_clr && (rx_data != m_xor);
      check("clr_rx_rdy", clr_rx_rdy, exp_clr);
      check("start", start, (cyc == m_start_due));
      check("busy", busy, (m_pix != 0) || m_waiting || m_ck_pending);
      check("frame_err", frame_err, exp_err);
      if (qchk_q) begin
        exp_q = (int'(addr_q) < NUM_PIXELS) ? model_mem[int'(addr_q)] : 1'b0;
        check($sformatf("q_input[%0d]", addr_q), q_input, exp_q);
      end
      if (start) start_count++;
      if (frame_err) err_count++;

      // core_done counts only once the start cycle has passed.
      if (m_waiting && core_done && cyc > m_start_due) begin
        m_waiting = 1'b0;
        m_free_at = cyc + 1;
      end

      if (exp_clr) begin
        if (m_ck_pending) begin
          m_ck_pending = 1'b0;
          if (rx_data == m_xor) begin
            m_start_due = cyc + 1;
            m_waiting   = 1'b1;
          end else begin
            m_free_at = cyc + 1;
            m_pix     = 0;
          end
          m_xor = 8'h00;
        end else begin
          for (int i = 0; i < 8; i++) model_mem[m_pix + i] = rx_data[i];
          m_pix     = m_pix + 8;
          m_xor     = m_xor ^ rx_data;
          m_free_at = cyc + 9;
          if (m_pix == NUM_PIXELS) begin
            m_pix = 0;
`ifdef IMG_CHECKSUM_EN
            m_ck_pending = 1'b1;
`else
            m_start_due = cyc + 9;
            m_waiting   = 1'b1;
`endif
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) tick();
    rx_data = b;
    rx_rdy  = 1'b1;
    for (int t = 0; t < 4000; t++) begin
      @(negedge clk);
      if (clr_rx_rdy) begin
        tick();
        rx_rdy = 1'b0;
        return;
      end
    end
    n_checks++;
    n_fail++;
    $display("FAIL send_byte: byte %0h not consumed within 4000 cycles, required consumption", b);
    rx_rdy = 1'b0;
  endtask

  // Sends a frame whose first byte is `first` and the rest `fill`; with the
  // checksum build the XOR of all data bytes (flipped by ck_flip) follows.
  task automatic send_frame(input logic [7:0] first, input logic [7:0] fill, input int gap_max,
                            input bit skip_first, input logic [7:0] ck_flip);
    logic [7:0] x;
    x = first;
    if (!skip_first) send_byte(first, $urandom_range(gap_max, 0));
    for (int k = 1; k < IMG_BYTES; k++) begin
      send_byte(fill, $urandom_range(gap_max, 0));
      x = x ^ fill;
    end
`ifdef IMG_CHECKSUM_EN
    send_byte(x ^ ck_flip, 0);
`else
    x = x ^ ck_flip;
`endif
  endtask

  task automatic sweep(input int last);
    qchk = 1'b1;
    for (int a = 0; a <= last; a++) begin
      tick();
      addr_input_unit = PIX_W'(a);
    end
    tick();
    qchk = 1'b0;
  endtask

  task automatic read_px(input int a, input bit exp, input string name);
    tick();
    addr_input_unit = PIX_W'(a);
    tick();
    check(name, q_input, exp);
  endtask

  task automatic pulse_core_done();
    tick();
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required $finish before it");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] bp_byte;
    logic [7:0] a5;
    int starts_before;
    bp_byte = 8'h96;
    a5      = 8'hA5;

    // Reset state.
    repeat (3) tick();
    check("rst_clr_rx_rdy", clr_rx_rdy, 0);
    check("rst_q_input", q_input, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    tick();

    // All-ones frame with random gaps between bytes.
    send_frame(8'hFF, 8'hFF, 20, 1'b0, 8'h00);
    repeat (12) tick();
    check("ones_start_count", start_count, 1);
    check("ones_busy_waiting", busy, 1);
    sweep(NUM_PIXELS - 1);
    read_px(783, 1'b1, "ones_px783");
    pulse_core_done();
    tick();
    check("ones_busy_after_done", busy, 0);

    // Pattern frame 0x01: only pixels 8k are set.
    send_frame(8'h01, 8'h01, 3, 1'b0, 8'h00);
    repeat (12) tick();
    check("pat_start_count", start_count, 2);
    sweep(1023);
    read_px(0, 1'b1, "pat_px0");
    read_px(1, 1'b0, "pat_px1");
    read_px(8, 1'b1, "pat_px8");
    read_px(783, 1'b0, "pat_px783");
    read_px(800, 1'b0, "pat_px800");

    // Backpressure + simultaneous core_done/rx_rdy while in WAIT_DONE.
    fork
      send_byte(bp_byte, 0);
      begin
        repeat (20) tick();
        core_done = 1'b1;
        @(negedge clk);
        check("sim_clr_with_done", clr_rx_rdy, 0);
        check("sim_busy_with_done", busy, 1);
        tick();
        core_done = 1'b0;
        @(negedge clk);
        check("sim_clr_after_done", clr_rx_rdy, 1);
        check("sim_busy_after_done", busy, 0);
        tick();
        @(negedge clk);
        check("sim_busy_reload", busy, 1);
      end
    join
    tick();
    send_frame(bp_byte, 8'h00, 1, 1'b1, 8'h00);
    repeat (12) tick();
    check("bp_start_count", start_count, 3);
    sweep(15);
    for (int i = 0; i < 8; i++) read_px(i, bp_byte[i], $sformatf("bp_px%0d", i));
    read_px(8, 1'b0, "bp_px8");
    pulse_core_done();

    // Reset in the middle of a frame, then a full 0xA5 frame.
    for (int k = 0; k < 50; k++) send_byte(8'h33, 0);
    repeat (12) tick();
    check("mid_busy_before_reset", busy, 1);
    rst_n = 1'b0;
    repeat (2) tick();
    check("mid_busy_in_reset", busy, 0);
    rst_n = 1'b1;
    tick();
    starts_before = start_count;
    send_frame(a5, a5, 2, 1'b0, 8'h00);
    repeat (12) tick();
    check("a5_start_count", start_count, starts_before + 1);
    check("a5_total_starts", start_count, 4);
    sweep(NUM_PIXELS - 1);
    for (int i = 0; i < 8; i++) read_px(i, a5[i], $sformatf("a5_px%0d", i));
    for (int i = 0; i < 8; i++) read_px(776 + i, a5[i], $sformatf("a5_px%0d", 776 + i));
    pulse_core_done();

`ifdef IMG_CHECKSUM_EN
    // 98 x 0x3C XORs to 0x00.
    send_frame(8'h3C, 8'h3C, 1, 1'b0, 8'h00);
    repeat (12) tick();
    check("ck_good_start_count", start_count, 5);
    pulse_core_done();
    send_frame(8'h3C, 8'h3C, 1, 1'b0, 8'h01);
    repeat (12) tick();
    check("ck_bad_err_count", err_count, 1);
    check("ck_bad_no_start", start_count, 5);
    check("ck_bad_busy", busy, 0);
    send_frame(8'h3C, 8'h3C, 1, 1'b0, 8'h00);
    repeat (12) tick();
    check("ck_recover_start_count", start_count, 6);
    pulse_core_done();
`endif

    repeat (5) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
